// File: rtl/neotang_rom_pkg.sv
// Shared ROM-loader types: address/word widths and the packed SDRAM write word.
package neotang_rom_pkg;
  localparam int ROM_ADDR_W = 25;
  localparam int ROM_WORD_W = 16;

  typedef struct packed {
    logic [ROM_ADDR_W-1:0] addr;
    logic [ROM_WORD_W-1:0] data;
    logic [1:0]            be;
  } rom_word_t;

  // 1 when the byte at this address lands in data[15:8]
  function automatic logic hi_lane(input logic a0, input logic big_endian);
    return big_endian ? ~a0 : a0;
  endfunction
endpackage

// File: rtl/rom_pack_fifo.sv
// Synchronous FIFO of rom_word_t; pointers wrap modulo DEPTH, occupancy counter tells full from empty.
module rom_pack_fifo
  import neotang_rom_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  rom_word_t              wdata,
  input  logic                   pop,
  output rom_word_t              rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  rom_word_t     mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a push into a full FIFO is fine when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/rom_write_packer.sv
// Packs a ROM byte stream into 16-bit SDRAM write words with byte enables, buffered in a small FIFO.
module rom_write_packer
  import neotang_rom_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ROM_ADDR_W-1:0] in_addr,
  input  logic [7:0]            in_data,
  input  logic                  in_wr,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [ROM_ADDR_W-1:0] out_addr,
  output logic [ROM_WORD_W-1:0] out_data,
  output logic [1:0]            out_be,
  output logic                  out_req,
  input  logic                  out_ack,
  output logic                  busy,
  output logic                  overflow,
  output logic [23:0]           word_count
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rom_word_t             pend, pend_n, push_word, head;
  logic                  pv, pv_n, flush_lat, flush_lat_n;
  logic                  accept, lane_hi, push, pop, full, empty, in_ready_n;
  logic [1:0]            lane_be;
  logic [ROM_WORD_W-1:0] lane_data;
  logic [ROM_ADDR_W-1:0] waddr;
  logic [CW-1:0]         count, count_n;

  rom_pack_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .wdata(push_word), .pop(pop),
    .rdata(head), .full(full), .empty(empty), .count(count)
  );

  always_comb begin
    accept      = in_wr & in_ready;
    lane_hi     = hi_lane(in_addr[0], BIG_ENDIAN);
    lane_be     = lane_hi ? 2'b10 : 2'b01;
    lane_data   = lane_hi ? {in_data, 8'h00} : {8'h00, in_data};
    waddr       = {in_addr[ROM_ADDR_W-1:1], 1'b0};
    pend_n      = pend;
    pv_n        = pv;
    flush_lat_n = flush_lat;
    push        = 1'b0;
    push_word   = pend;
    if (accept) begin
      if (pv && pend.addr == waddr && (pend.be & lane_be) == 2'b00) begin
        pend_n.data = pend.data | lane_data;
        pend_n.be   = pend.be | lane_be;
        if (pend_n.be == 2'b11) begin
          push      = 1'b1;
          push_word = pend_n;
          pv_n      = 1'b0;
          pend_n    = '0;
        end
      end else begin
        // evict whatever is pending (possibly partial) and start a new word
        push   = pv;
        pv_n   = 1'b1;
        pend_n = '{addr: waddr, data: lane_data, be: lane_be};
      end
      flush_lat_n = flush;
    end else if (flush && in_wr) begin
      flush_lat_n = 1'b1;
    end else if (flush || flush_lat) begin
      if (!pv) begin
        flush_lat_n = 1'b0;
      end else if (!full) begin
        push        = 1'b1;
        pv_n        = 1'b0;
        pend_n      = '0;
        flush_lat_n = 1'b0;
      end else begin
        flush_lat_n = 1'b1;
      end
    end
    pop        = out_ack & out_req;
    count_n    = count + CW'(push) - CW'(pop);
    in_ready_n = (count_n != CW'(FIFO_DEPTH)) && !flush_lat_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend       <= '0;
      pv         <= 1'b0;
      flush_lat  <= 1'b0;
      in_ready   <= 1'b1;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      pend      <= pend_n;
      pv        <= pv_n;
      flush_lat <= flush_lat_n;
      in_ready  <= in_ready_n;
      if (in_wr && !in_ready) overflow <= 1'b1;
      if (pop && word_count != '1) word_count <= word_count + 24'd1;
    end
  end

  // reset gates the request so stale buffered words never show in the reset cycle
  assign out_req  = ~empty & ~reset;
  assign out_addr = out_req ? head.addr : '0;
  assign out_data = out_req ? head.data : '0;
  assign out_be   = out_req ? head.be   : '0;
  assign busy     = pv | ~empty;
endmodule

// File: tb/tb_rom_write_packer.sv
// Self-checking bench for rom_write_packer: vector table, directed corner sequences, random image check.
module tb_rom_write_packer;
  import neotang_rom_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [ROM_ADDR_W-1:0] in_addr = '0;
  logic [7:0]            in_data = '0;
  logic                  in_wr = 1'b0;
  logic                  in_ready;
  logic                  flush = 1'b0;
  logic [ROM_ADDR_W-1:0] out_addr;
  logic [ROM_WORD_W-1:0] out_data;
  logic [1:0]            out_be;
  logic                  out_req;
  logic                  out_ack = 1'b0;
  logic                  busy;
  logic                  overflow;
  logic [23:0]           word_count;

  rom_write_packer #(.FIFO_DEPTH(8), .BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_addr(in_addr), .in_data(in_data), .in_wr(in_wr),
    .in_ready(in_ready), .flush(flush), .out_addr(out_addr), .out_data(out_data),
    .out_be(out_be), .out_req(out_req), .out_ack(out_ack), .busy(busy),
    .overflow(overflow), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int        checks = 0;
  int        errors = 0;
  rom_word_t got_q[$];

  typedef struct {
    logic [24:0] a0;
    logic [7:0]  d0;
    logic [24:0] a1;
    logic [7:0]  d1;
    int          nw;
    rom_word_t   w0;
    rom_word_t   w1;
  } vec_t;

  function automatic rom_word_t mkw(input logic [24:0] a, input logic [15:0] d, input logic [1:0] be);
    rom_word_t w;
    w.addr = a;
    w.data = d;
    w.be   = be;
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_wr = 1'b0; flush = 1'b0; out_ack = 1'b0; reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    in_addr = a; in_data = d; in_wr = 1'b1;
    tick();
    in_wr = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // acks every offered word for a fixed number of cycles, collecting them in got_q
  task automatic drain(input int cycles);
    got_q.delete();
    for (int c = 0; c < cycles; c++) begin
      if (out_req) begin
        got_q.push_back(mkw(out_addr, out_data, out_be));
        out_ack = 1'b1;
      end else begin
        out_ack = 1'b0;
      end
      tick();
    end
    out_ack = 1'b0;
  endtask

  vec_t          tbl[6];
  rom_word_t     act_w;
  logic [7:0]    exp_img[int];
  logic [7:0]    got_img[int];
  int            hs, a, bad;

  task automatic record(input rom_word_t w);
    if (w.be[1]) got_img[int'(w.addr)]     = w.data[15:8];
    if (w.be[0]) got_img[int'(w.addr) + 1] = w.data[7:0];
  endtask

  initial begin
    tbl[0] = '{25'h000, 8'h12, 25'h001, 8'h34, 1, mkw(25'h000, 16'h1234, 2'b11), mkw(0, 0, 0)};
    tbl[1] = '{25'h003, 8'hAA, 25'h010, 8'hBB, 2, mkw(25'h002, 16'h00AA, 2'b01), mkw(25'h010, 16'hBB00, 2'b10)};
    tbl[2] = '{25'h101, 8'h56, 25'h100, 8'h78, 1, mkw(25'h100, 16'h7856, 2'b11), mkw(0, 0, 0)};
    tbl[3] = '{25'h020, 8'h11, 25'h020, 8'h22, 2, mkw(25'h020, 16'h1100, 2'b10), mkw(25'h020, 16'h2200, 2'b10)};
    tbl[4] = '{25'h1FFFFFF, 8'hCD, 25'h1FFFFFE, 8'hEF, 1, mkw(25'h1FFFFFE, 16'hEFCD, 2'b11), mkw(0, 0, 0)};
    tbl[5] = '{25'h041, 8'h01, 25'h043, 8'h02, 2, mkw(25'h040, 16'h0001, 2'b01), mkw(25'h042, 16'h0002, 2'b01)};

    // reset state
    do_reset();
    chk("rst in_ready", in_ready, 1);
    chk("rst out_req", out_req, 0);
    chk("rst out_be", out_be, 0);
    chk("rst out_addr", out_addr, 0);
    chk("rst out_data", out_data, 0);
    chk("rst busy", busy, 0);
    chk("rst overflow", overflow, 0);
    chk("rst word_count", word_count, 0);

    // vector table: two bytes, flush, then collect words
    foreach (tbl[i]) begin
      send_byte(tbl[i].a0, tbl[i].d0);
      send_byte(tbl[i].a1, tbl[i].d1);
      pulse_flush();
      drain(12);
      chk($sformatf("vec%0d nwords", i), got_q.size(), tbl[i].nw);
      for (int k = 0; k < tbl[i].nw; k++) begin
        act_w = (k < got_q.size()) ? got_q[k] : '1;
        chk($sformatf("vec%0d word%0d", i, k), act_w, (k == 0) ? tbl[i].w0 : tbl[i].w1);
      end
      chk($sformatf("vec%0d busy", i), busy, 0);
      if (i == 0) chk("vec0 word_count", word_count, 1);
    end

    // latency and flush with nothing pending
    do_reset();
    send_byte(25'h200, 8'h01);
    chk("lat partial no req", out_req, 0);
    chk("lat partial busy", busy, 1);
    send_byte(25'h201, 8'h02);
    chk("lat word visible", out_req, 1);
    drain(6);
    pulse_flush();
    tick();
    chk("empty flush no req", out_req, 0);
    chk("empty flush busy", busy, 0);

    // overflow: 18 bytes with no ack
    do_reset();
    in_wr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_addr = 25'(i); in_data = 8'(i + 1);
      tick();
    end
    chk("ovf full in_ready", in_ready, 0);
    chk("ovf not yet", overflow, 0);
    for (int i = 16; i < 18; i++) begin
      in_addr = 25'(i); in_data = 8'(i + 1);
      tick();
    end
    in_wr = 1'b0;
    chk("ovf set", overflow, 1);
    drain(30);
    chk("ovf drained words", got_q.size(), 8);
    for (int k = 0; k < 8; k++) begin
      act_w = (k < got_q.size()) ? got_q[k] : '1;
      chk($sformatf("ovf word%0d", k), act_w, mkw(25'(2*k), {8'(2*k+1), 8'(2*k+2)}, 2'b11));
    end
    chk("ovf word_count", word_count, 8);
    chk("ovf busy", busy, 0);
    chk("ovf sticky", overflow, 1);

    // flush while the FIFO is full stays latched
    do_reset();
    for (int i = 0; i < 14; i++) send_byte(25'(i), 8'(i));
    send_byte(25'h101, 8'h55);
    send_byte(25'h201, 8'h66);
    chk("ffull in_ready", in_ready, 0);
    pulse_flush();
    tick();
    chk("ffull busy", busy, 1);
    chk("ffull in_ready held", in_ready, 0);
    drain(30);
    chk("ffull nwords", got_q.size(), 9);
    act_w = (got_q.size() >= 9) ? got_q[7] : '1;
    chk("ffull word7", act_w, mkw(25'h100, 16'h0055, 2'b01));
    act_w = (got_q.size() >= 9) ? got_q[8] : '1;
    chk("ffull word8", act_w, mkw(25'h200, 16'h0066, 2'b01));
    chk("ffull in_ready back", in_ready, 1);
    chk("ffull idle", busy, 0);

    // completing byte and flush in the same cycle
    do_reset();
    send_byte(25'h300, 8'hA1);
    in_addr = 25'h301; in_data = 8'hB2; in_wr = 1'b1; flush = 1'b1;
    tick();
    in_wr = 1'b0; flush = 1'b0;
    chk("bf in_ready latched", in_ready, 0);
    chk("bf req", out_req, 1);
    tick();
    chk("bf in_ready back", in_ready, 1);
    drain(10);
    chk("bf nwords", got_q.size(), 1);
    act_w = (got_q.size() > 0) ? got_q[0] : '1;
    chk("bf word", act_w, mkw(25'h300, 16'hA1B2, 2'b11));
    chk("bf busy", busy, 0);

    // reset mid-operation
    do_reset();
    for (int i = 0; i < 7; i++) send_byte(25'(25'h400 + i), 8'(8'h40 + i));
    chk("mid pre req", out_req, 1);
    reset = 1'b1;
    #1;
    chk("mid reset cycle req", out_req, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid after req", out_req, 0);
    chk("mid after busy", busy, 0);
    tick();
    chk("mid next req", out_req, 0);
    send_byte(25'h500, 8'h5A);
    send_byte(25'h501, 8'hA5);
    drain(10);
    chk("mid nwords", got_q.size(), 1);
    act_w = (got_q.size() > 0) ? got_q[0] : '1;
    chk("mid word", act_w, mkw(25'h500, 16'h5AA5, 2'b11));

    // random stream vs memory image
    do_reset();
    hs = 0;
    for (int c = 0; c < 1500; c++) begin
      out_ack = ($urandom_range(0, 1) == 1);
      if (out_req && out_ack) begin
        record(mkw(out_addr, out_data, out_be));
        hs++;
      end
      in_wr = 1'b0; flush = 1'b0;
      if (in_ready && $urandom_range(0, 9) < 7) begin
        a = 32'h1000 + int'($urandom_range(0, 47));
        in_addr = 25'(a);
        in_data = 8'($urandom);
        in_wr = 1'b1;
        exp_img[a] = in_data;
      end else if ($urandom_range(0, 29) == 0) begin
        flush = 1'b1;
      end
      tick();
    end
    in_wr = 1'b0; out_ack = 1'b0;
    pulse_flush();
    for (int c = 0; c < 40; c++) begin
      out_ack = out_req;
      if (out_req) begin
        record(mkw(out_addr, out_data, out_be));
        hs++;
      end
      tick();
    end
    out_ack = 1'b0;
    bad = 0;
    foreach (exp_img[k]) begin
      if (!got_img.exists(k) || got_img[k] !== exp_img[k]) bad++;
    end
    chk("rand image size", got_img.num(), exp_img.num());
    chk("rand image bytes bad", bad, 0);
    chk("rand word_count", word_count, 24'(hs));
    chk("rand busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
